// File: rtl/store_unit.sv
// store_unit: data-memory write path of the CPU.
// Formats SB/SH/SW store requests into lane-positioned write data and byte
// strobes for a word-organised memory, splitting stores that cross a word
// boundary into two word-aligned beats.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready CPU-side handshake
//   req_addr            byte address of the store
//   req_data            rs2 value (low bytes used)
//   req_funct3          000 SB, 001 SH, 010 SW; anything else is illegal
//   mem_valid/mem_ready memory-side handshake
//   mem_addr            word-aligned beat address
//   mem_wdata           lane-positioned write data, unused lanes zero
//   mem_wstrb           byte strobes, bit i = lane i
//   done                one-cycle pulse when a request finishes
//   err                 one-cycle pulse with done on a rejected request
module store_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [2:0]  req_funct3,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1
  } state_t;

  state_t state, state_next;

  // Second-beat payload captured at accept, presented after beat0 handshakes.
  logic [31:0] beat1_addr;
  logic [31:0] beat1_data;
  logic [3:0]  beat1_strb;
  logic        beat1_needed;

  logic        accept;
  logic        legal;
  logic        reject;
  logic [1:0]  off;
  logic [3:0]  mask;
  logic [31:0] data_masked;
  logic [63:0] shifted_data;
  logic [7:0]  shifted_strb;
  logic        crossing;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  // mem_valid is a pure decode of the state register so that an async reset
  // drops it immediately.
  assign mem_valid = (state != IDLE);

  assign off = req_addr[1:0];

  always_comb begin
    mask        = '0;
    data_masked = '0;
    legal       = 1'b1;
    case (req_funct3)
      3'b000: begin
        mask        = 4'b0001;
        data_masked = {24'd0, req_data[7:0]};
      end
      3'b001: begin
        mask        = 4'b0011;
        data_masked = {16'd0, req_data[15:0]};
      end
      3'b010: begin
        mask        = 4'b1111;
        data_masked = req_data;
      end
      default: legal = 1'b0;
    endcase
  end

  assign shifted_data = {32'd0, data_masked} << {off, 3'b000};
  assign shifted_strb = {4'd0, mask} << off;
  assign crossing     = |shifted_strb[7:4];
  assign reject       = !legal || (crossing && !ALLOW_MISALIGNED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !reject) state_next = BEAT0;
      BEAT0:   if (mem_ready) state_next = beat1_needed ? BEAT1 : IDLE;
      BEAT1:   if (mem_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      beat1_addr   <= '0;
      beat1_data   <= '0;
      beat1_strb   <= '0;
      beat1_needed <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (reject) begin
              done <= 1'b1;
              err  <= 1'b1;
            end else begin
              mem_addr     <= {req_addr[31:2], 2'b00};
              mem_wdata    <= shifted_data[31:0];
              mem_wstrb    <= shifted_strb[3:0];
              beat1_addr   <= {req_addr[31:2], 2'b00} + 32'd4;
              beat1_data   <= shifted_data[63:32];
              beat1_strb   <= shifted_strb[7:4];
              beat1_needed <= crossing;
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            if (beat1_needed) begin
              mem_addr  <= beat1_addr;
              mem_wdata <= beat1_data;
              mem_wstrb <= beat1_strb;
            end else begin
              done <= 1'b1;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_store_unit.sv
module tb_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [31:0] req_addr, req_data;
  logic [2:0]  req_funct3;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        done, err;

  logic        nm_req_valid, nm_req_ready;
  logic [31:0] nm_req_addr, nm_req_data;
  logic [2:0]  nm_req_funct3;
  logic        nm_mem_valid, nm_mem_ready;
  logic [31:0] nm_mem_addr, nm_mem_wdata;
  logic [3:0]  nm_mem_wstrb;
  logic        nm_done, nm_err;

  int unsigned n_compared = 0;
  int unsigned n_mismatched = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  store_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_funct3(req_funct3),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .done(done), .err(err)
  );

  store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
    .clk(clk), .rst(rst),
    .req_valid(nm_req_valid), .req_ready(nm_req_ready),
    .req_addr(nm_req_addr), .req_data(nm_req_data), .req_funct3(nm_req_funct3),
    .mem_valid(nm_mem_valid), .mem_ready(nm_mem_ready),
    .mem_addr(nm_mem_addr), .mem_wdata(nm_mem_wdata), .mem_wstrb(nm_mem_wstrb),
    .done(nm_done), .err(nm_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_compared++;
    assert (obs === expv) else begin
      n_mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte-by-byte reference: each written byte lands in the word holding its
  // address; a new beat starts whenever that word changes.
  task automatic push_expected(input logic [31:0] addr, input logic [31:0] data,
                               input logic [2:0] f3);
    int unsigned size;
    beat_t bt[2];
    int unsigned nb;
    logic [31:0] a, w;
    logic [1:0] lane;
    size = (f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4;
    nb = 0;
    for (int unsigned i = 0; i < size; i++) begin
      a = addr + i;
      w = {a[31:2], 2'b00};
      lane = a[1:0];
      if (nb == 0 || bt[nb-1].addr != w) begin
        bt[nb].addr = w;
        bt[nb].data = '0;
        bt[nb].strb = '0;
        nb++;
      end
      bt[nb-1].data[lane*8 +: 8] = data[i*8 +: 8];
      bt[nb-1].strb[lane] = 1'b1;
    end
    for (int unsigned i = 0; i < nb; i++) exp_q.push_back(bt[i]);
  endtask

  task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    chk("req_ready_idle", 64'(req_ready), 64'(1'b1));
    req_valid  = 1'b1;
    req_addr   = addr;
    req_data   = data;
    req_funct3 = f3;
    step();
    req_valid  = 1'b0;
  endtask

  // Compares the next scoreboard beat, holding mem_ready low for 'stall'
  // cycles first, then completes the handshake.
  task automatic expect_beat(input string tag, input int unsigned stall);
    beat_t e;
    chk({tag, "_sb_nonempty"}, 64'(exp_q.size() > 0), 64'(1'b1));
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    mem_ready = 1'b0;
    for (int unsigned c = 0; c <= stall; c++) begin
      if (c == stall) mem_ready = 1'b1;
      chk({tag, "_valid"},     64'(mem_valid), 64'(1'b1));
      chk({tag, "_addr"},      64'(mem_addr),  64'(e.addr));
      chk({tag, "_wdata"},     64'(mem_wdata), 64'(e.data));
      chk({tag, "_wstrb"},     64'(mem_wstrb), 64'(e.strb));
      chk({tag, "_req_ready"}, 64'(req_ready), 64'(1'b0));
      chk({tag, "_done_low"},  64'(done),      64'(1'b0));
      step();
    end
    mem_ready = 1'b0;
  endtask

  task automatic expect_done(input string tag);
    chk({tag, "_done"},      64'(done),      64'(1'b1));
    chk({tag, "_err"},       64'(err),       64'(1'b0));
    chk({tag, "_valid_off"}, 64'(mem_valid), 64'(1'b0));
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(1'b1));
    step();
    chk({tag, "_done_pulse"}, 64'(done), 64'(1'b0));
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] f3, input int unsigned stall);
    int unsigned nbeats;
    push_expected(addr, data, f3);
    nbeats = exp_q.size();
    issue(addr, data, f3);
    for (int unsigned b = 0; b < nbeats; b++)
      expect_beat($sformatf("%s_b%0d", tag, b), stall);
    expect_done(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_data = '0; req_funct3 = '0;
    mem_ready = 1'b0;
    nm_req_valid = 1'b0; nm_req_addr = '0; nm_req_data = '0; nm_req_funct3 = '0;
    nm_mem_ready = 1'b1;
    step();
    step();
    chk("rst_mem_valid", 64'(mem_valid), 64'(1'b0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(32'h0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(32'h0));
    chk("rst_mem_wstrb", 64'(mem_wstrb), 64'(4'h0));
    chk("rst_done",      64'(done),      64'(1'b0));
    chk("rst_err",       64'(err),       64'(1'b0));
    chk("rst_req_ready", 64'(req_ready), 64'(1'b0));
    rst = 1'b0;
    step();

    do_store("sw_aligned", 32'h0000_1000, 32'h1122_3344, 3'b010, 0);
    do_store("sb_lane2",   32'h0000_1002, 32'h1234_5678, 3'b000, 0);
    do_store("sh_split",   32'h0000_2003, 32'h0000_ABCD, 3'b001, 0);
    do_store("sw_wrap",    32'hFFFF_FFFD, 32'hA1B2_C3D4, 3'b010, 3);
    do_store("sh_aligned", 32'h0000_3002, 32'hDEAD_BEEF, 3'b001, 1);

    // Illegal funct3: no beat, done+err for one cycle.
    mem_ready = 1'b1;
    issue(32'h0000_4000, 32'h5555_AAAA, 3'b011);
    chk("ill_valid", 64'(mem_valid), 64'(1'b0));
    chk("ill_done",  64'(done),      64'(1'b1));
    chk("ill_err",   64'(err),       64'(1'b1));
    step();
    chk("ill_valid2",    64'(mem_valid), 64'(1'b0));
    chk("ill_done_low",  64'(done),      64'(1'b0));
    chk("ill_err_low",   64'(err),       64'(1'b0));
    mem_ready = 1'b0;

    // Crossing SH with misalignment disallowed.
    chk("nm_req_ready", 64'(nm_req_ready), 64'(1'b1));
    nm_req_valid = 1'b1; nm_req_addr = 32'h0000_2003;
    nm_req_data = 32'h0000_ABCD; nm_req_funct3 = 3'b001;
    step();
    nm_req_valid = 1'b0;
    chk("nm_valid", 64'(nm_mem_valid), 64'(1'b0));
    chk("nm_done",  64'(nm_done),      64'(1'b1));
    chk("nm_err",   64'(nm_err),       64'(1'b1));
    step();
    chk("nm_valid2",   64'(nm_mem_valid), 64'(1'b0));
    chk("nm_done_low", 64'(nm_done),      64'(1'b0));
    chk("nm_err_low",  64'(nm_err),       64'(1'b0));

    // Reset during a stalled second beat.
    push_expected(32'h0000_2003, 32'h0000_ABCD, 3'b001);
    issue(32'h0000_2003, 32'h0000_ABCD, 3'b001);
    expect_beat("rst_case_b0", 0);
    chk("rst_case_b1_valid", 64'(mem_valid), 64'(1'b1));
    chk("rst_case_b1_addr",  64'(mem_addr),  64'(32'h0000_2004));
    step();
    chk("rst_case_b1_hold",  64'(mem_wdata), 64'(32'h0000_00AB));
    rst = 1'b1;
    #1;
    chk("rst_case_valid_drop", 64'(mem_valid), 64'(1'b0));
    chk("rst_case_ready_low",  64'(req_ready), 64'(1'b0));
    exp_q.delete();
    step();
    rst = 1'b0;
    #1;
    chk("rst_case_ready_after", 64'(req_ready), 64'(1'b1));
    chk("rst_case_no_done",     64'(done),      64'(1'b0));
    step();
    chk("rst_case_no_done2",    64'(done),      64'(1'b0));
    do_store("sw_after_rst", 32'h0000_5004, 32'hCAFE_F00D, 3'b010, 0);

    chk("sb_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Data-memory write path of the CPU, running opposite to the register write-back/load-extension path.
- Takes a store request (address, rs2 data, funct3 for SB/SH/SW) and formats byte-lane data and write strobes for a word-organised data memory.
- Splits stores that cross a word boundary into two word-aligned beats.
- Handshakes with the CPU on a valid/ready interface and with memory on a valid/ready interface.

Parameters:
- ALLOW_MISALIGNED, 1, 1 = split boundary-crossing SH/SW into two beats; 0 = reject them with err.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  store request present
- req_ready  out  1  unit can accept a request
- req_addr  in  32  byte address of the store
- req_data  in  32  rs2 value; low bytes are used
- req_funct3  in  3  000 SB, 001 SH, 010 SW; any other value is illegal
- mem_valid  out  1  memory beat valid
- mem_ready  in  1  memory accepts the beat (may be combinational on mem_valid)
- mem_addr  out  32  word-aligned beat address, bits[1:0] always 00
- mem_wdata  out  32  lane-positioned write data; lanes not written are 0
- mem_wstrb  out  4  byte strobes; bit i = byte lane i
- done  out  1  one-cycle pulse: request finished (success or error)
- err  out  1  one-cycle pulse together with done: illegal funct3 or rejected misalignment

Behaviour:
- Reset (async, immediate): state IDLE; mem_valid=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, done=0, err=0. req_ready=0 while rst is high.
- req_ready = (state==IDLE) and not rst. Acceptance happens on the rising edge where req_valid and req_ready are both 1.
- Formatting at accept:
  - off = req_addr[1:0].
  - mask = 0001 (SB), 0011 (SH), 1111 (SW).
  - size = 1, 2 or 4 bytes.
  - 64-bit shifted data D = zero-extended req_data masked to size, shifted left by 8*off.
  - 8-bit strobe S = mask << off.
  - Beat0: addr = {req_addr[31:2],00}, data = D[31:0], strb = S[3:0].
  - Beat1 (only if S[7:4] is nonzero): addr = beat0 addr + 4 modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000; data = D[63:32], strb = S[7:4].
- State machine IDLE / BEAT0 / BEAT1:
  - IDLE, legal accept → BEAT0. mem_valid rises the cycle after accept; all beat outputs are registered.
  - IDLE, accept of illegal funct3, or of a crossing store when ALLOW_MISALIGNED=0 → stay IDLE. No memory beat is issued. done=err=1 in the next cycle.
  - BEAT0, mem_ready=1 → BEAT1 if a second beat is needed, else IDLE.
  - BEAT1, mem_ready=1 → IDLE.
  - While mem_valid=1 and mem_ready=0: mem_addr, mem_wdata and mem_wstrb are held stable.
- mem_valid deassertion: mem_valid drops in the cycle after the final handshake unless a next beat loads. Between BEAT0 and BEAT1 mem_valid stays 1 with the new beat values and no bubble.
- done timing: done pulses for exactly one cycle, the cycle after the final handshake. State is IDLE in that cycle, so req_ready=1 and a new request may be accepted in that same cycle.
- Latency:
  - aligned store with mem_ready tied high: accept edge, beat in the next cycle, done the cycle after that.
  - split store: one additional cycle.
- Outputs in IDLE: mem_wdata and mem_wstrb keep their last values; mem_wstrb is only meaningful while mem_valid=1.
- Reset mid-operation: the beat is aborted, mem_valid drops asynchronously, no done is produced, and any pending second beat is discarded.

Test Plan:
- SW addr 0x00001000, data 0x11223344, mem_ready=1 → one beat: addr 0x1000, wdata 0x11223344, wstrb 1111; done (no err) two cycles after accept.
- SB addr 0x00001002, data 0x12345678 → one beat: addr 0x1000, wdata 0x00780000, wstrb 0100.
- SH addr 0x00002003, data 0x0000ABCD → beat0: 0x2000 / 0xCD000000 / 1000; beat1: 0x2004 / 0x000000AB / 0001; mem_valid continuous across both beats; single done.
- SW addr 0xFFFFFFFD, data 0xA1B2C3D4, mem_ready low for 3 cycles on each beat → beat0: 0xFFFFFFFC / 0xB2C3D400 / 1110; beat1: 0x00000000 / 0x000000A1 / 0001; outputs stable while stalled; req_ready=0 throughout.
- funct3=011, and a repeat of the SH 0x2003 case with ALLOW_MISALIGNED=0 → no mem_valid; done=err=1 for one cycle.
- rst pulsed during stalled beat1 → mem_valid=0 immediately; no done; req_ready=1 in the first cycle after rst falls; a following aligned SW completes normally.
